sram_dual_req_arbiter: RTL and testbench

- Shares one single-port SRAM macro (4096x32, byte write mask, registered dout) between two requesters, A and B.
- Each requester has a valid/ready request channel and a valid/ready read-response channel.
- Grants are round-robin, with at most one outstanding read per requester.
- Registers all macro inputs, captures macro dout on the correct cycle, and routes it to the issuing requester.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_rsp_slot.sv | 59 +++++
 rtl/sram_dual_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_dual_req_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared widths, read latency and port identifiers for the dual-requester SRAM arbiter.
package sram_arb_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_WMASK_WIDTH = DEF_DATA_WIDTH / 8;

    // Accept-to-visible response latency: issue register + macro dout register + capture.
    localparam int READ_LATENCY = 3;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

endpackage

// File: rtl/sram_rsp_slot.sv
// Per-requester read bookkeeping: outstanding flag and the held response with its handshake.
module sram_rsp_slot
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_issue_i,
    input  logic                  capture_i,
    input  logic [DATA_WIDTH-1:0] dout_i,
    input  logic                  rsp_ready_i,
    output logic                  outstanding_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o
);

    logic                  out_q, out_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  consume;

    assign consume = valid_q && rsp_ready_i;

    // Only one read can be in flight, so issue never collides with consume on the same slot.
    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        if (rd_issue_i) begin
            out_d = 1'b1;
        end else if (consume) begin
            out_d = 1'b0;
        end
        if (capture_i) begin
            valid_d = 1'b1;
            rdata_d = dout_i;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    assign outstanding_o = out_q;
    assign rsp_valid_o   = valid_q;
    assign rsp_rdata_o   = rdata_q;

endmodule

// File: rtl/sram_dual_req_arbiter.sv
// Round-robin sharing of one single-port SRAM macro between requesters A and B.
// Macro inputs are registered; read data is steered back to its issuer through a tag pipe.
module sram_dual_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WMASK_WIDTH = DEF_WMASK_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_req_valid,
    output logic                   a_req_ready,
    input  logic                   a_req_we,
    input  logic [WMASK_WIDTH-1:0] a_req_wmask,
    input  logic [ADDR_WIDTH-1:0]  a_req_addr,
    input  logic [DATA_WIDTH-1:0]  a_req_wdata,
    output logic                   a_rsp_valid,
    input  logic                   a_rsp_ready,
    output logic [DATA_WIDTH-1:0]  a_rsp_rdata,
    input  logic                   b_req_valid,
    output logic                   b_req_ready,
    input  logic                   b_req_we,
    input  logic [WMASK_WIDTH-1:0] b_req_wmask,
    input  logic [ADDR_WIDTH-1:0]  b_req_addr,
    input  logic [DATA_WIDTH-1:0]  b_req_wdata,
    output logic                   b_rsp_valid,
    input  logic                   b_rsp_ready,
    output logic [DATA_WIDTH-1:0]  b_rsp_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int TAG_STAGES = READ_LATENCY - 1;

    logic a_out, b_out;
    logic elig_a, elig_b, gnt_a, gnt_b, any_gnt;
    logic cap_a, cap_b;

    logic                   iss_we;
    logic [WMASK_WIDTH-1:0] iss_wmask;
    logic [ADDR_WIDTH-1:0]  iss_addr;
    logic [DATA_WIDTH-1:0]  iss_wdata;

    port_id_e               rr_q, rr_d;
    logic                   sram_we_q, sram_we_d;
    logic [WMASK_WIDTH-1:0] sram_wmask_q, sram_wmask_d;
    logic [ADDR_WIDTH-1:0]  sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0]  sram_din_q, sram_din_d;
    logic [TAG_STAGES-1:0]  tag_vld_q, tag_vld_d;
    logic [TAG_STAGES-1:0]  tag_b_q, tag_b_d;

    // A port with a read in flight may still write; only its next read waits.
    assign elig_a  = a_req_valid && (a_req_we || !a_out);
    assign elig_b  = b_req_valid && (b_req_we || !b_out);
    assign gnt_a   = elig_a && (!elig_b || (rr_q == PORT_A));
    assign gnt_b   = elig_b && !gnt_a;
    assign any_gnt = gnt_a || gnt_b;

    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;

    always_comb begin
        iss_we    = gnt_a ? a_req_we    : b_req_we;
        iss_wmask = gnt_a ? a_req_wmask : b_req_wmask;
        iss_addr  = gnt_a ? a_req_addr  : b_req_addr;
        iss_wdata = gnt_a ? a_req_wdata : b_req_wdata;

        rr_d = rr_q;
        if (gnt_a) begin
            rr_d = PORT_B;
        end else if (gnt_b) begin
            rr_d = PORT_A;
        end

        sram_we_d    = any_gnt && iss_we;
        sram_wmask_d = sram_we_d ? iss_wmask : '0;
        sram_addr_d  = any_gnt ? iss_addr : sram_addr_q;
        sram_din_d   = sram_we_d ? iss_wdata : sram_din_q;

        tag_vld_d = {tag_vld_q[TAG_STAGES-2:0], any_gnt && !iss_we};
        tag_b_d   = {tag_b_q[TAG_STAGES-2:0], gnt_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= PORT_A;
            sram_we_q    <= 1'b0;
            sram_wmask_q <= '0;
            sram_addr_q  <= '0;
            sram_din_q   <= '0;
            tag_vld_q    <= '0;
            tag_b_q      <= '0;
        end else begin
            rr_q         <= rr_d;
            sram_we_q    <= sram_we_d;
            sram_wmask_q <= sram_wmask_d;
            sram_addr_q  <= sram_addr_d;
            sram_din_q   <= sram_din_d;
            tag_vld_q    <= tag_vld_d;
            tag_b_q      <= tag_b_d;
        end
    end

    assign sram_we    = sram_we_q;
    assign sram_wmask = sram_wmask_q;
    assign sram_addr  = sram_addr_q;
    assign sram_din   = sram_din_q;

    // Last tag stage lines up with the cycle in which the macro presents the read word.
    assign cap_a = tag_vld_q[TAG_STAGES-1] && !tag_b_q[TAG_STAGES-1];
    assign cap_b = tag_vld_q[TAG_STAGES-1] &&  tag_b_q[TAG_STAGES-1];

    sram_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_issue_i    (gnt_a && !a_req_we),
        .capture_i     (cap_a),
        .dout_i        (sram_dout),
        .rsp_ready_i   (a_rsp_ready),
        .outstanding_o (a_out),
        .rsp_valid_o   (a_rsp_valid),
        .rsp_rdata_o   (a_rsp_rdata)
    );

    sram_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_issue_i    (gnt_b && !b_req_we),
        .capture_i     (cap_b),
        .dout_i        (sram_dout),
        .rsp_ready_i   (b_rsp_ready),
        .outstanding_o (b_out),
        .rsp_valid_o   (b_rsp_valid),
        .rsp_rdata_o   (b_rsp_rdata)
    );

endmodule

// File: tb/tb_sram_dual_req_arbiter.sv
// Bench for sram_dual_req_arbiter: behavioural macro, directed vector tables and a
// randomized phase checked against a cycle-level reference model.
module tb_sram_dual_req_arbiter;
    import sram_arb_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int MW = DEF_WMASK_WIDTH;

    typedef struct packed {
        logic          v;
        logic          we;
        logic [MW-1:0] wm;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          rr;
    } req_t;

    typedef struct packed {
        req_t          a;
        req_t          b;
        logic          cr;
        logic          ear;
        logic          ebr;
        logic          cs;
        logic          earv;
        logic [DW-1:0] eard;
        logic          ebrv;
        logic [DW-1:0] ebrd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
    logic b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
    logic [MW-1:0] a_req_wmask, b_req_wmask, sram_wmask;
    logic [AW-1:0] a_req_addr, b_req_addr, sram_addr;
    logic [DW-1:0] a_req_wdata, b_req_wdata, a_rsp_rdata, b_rsp_rdata;
    logic [DW-1:0] sram_din, sram_dout;
    logic          sram_we;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_dual_req_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_wmask(a_req_wmask), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_wmask(b_req_wmask), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Single-port macro: byte-masked write, registered dout, garbage on write cycles.
    logic [DW-1:0] mac_mem [1 << AW];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mac_mem[i] = '0;
        sram_dout = '0;
    end
    always @(posedge clk) begin
        if (sram_we) begin
            for (int l = 0; l < MW; l++)
                if (sram_wmask[l]) mac_mem[sram_addr][8*l +: 8] <= sram_din[8*l +: 8];
            sram_dout <= 32'hDEAD_0BAD;
        end else begin
            sram_dout <= mac_mem[sram_addr];
        end
    end

    // Reference model: memory image, pending reads with due cycles, held responses.
    logic [DW-1:0] m_mem [1 << AW];
    int            m_ptr;
    int            m_cyc;
    bit            m_out [2];
    bit            m_pend [2];
    int            m_pdue [2];
    logic [DW-1:0] m_pdata [2];
    bit            m_rv [2];
    logic [DW-1:0] m_rd [2];
    bit            m_we;
    logic [MW-1:0] m_wmask;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic          last_ar, last_br;

    task automatic m_reset();
        m_ptr = 0;
        for (int p = 0; p < 2; p++) begin
            m_out[p] = 0; m_pend[p] = 0; m_rv[p] = 0; m_rd[p] = '0;
        end
        m_we = 0; m_wmask = '0; m_addr = '0; m_din = '0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic req_t rq_idle(input bit rr);
        req_t r;
        r = '0;
        r.rr = rr;
        return r;
    endfunction

    function automatic req_t rq_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        req_t r;
        r = '0;
        r.v = 1; r.we = 1; r.wm = m; r.addr = a; r.wd = d; r.rr = 1;
        return r;
    endfunction

    function automatic req_t rq_rd(input logic [AW-1:0] a, input bit rr);
        req_t r;
        r = '0;
        r.v = 1; r.addr = a; r.rr = rr;
        return r;
    endfunction

    function automatic vec_t mkv(input req_t a, input req_t b, input bit ear, input bit ebr,
                                 input bit earv, input logic [DW-1:0] eard,
                                 input bit ebrv, input logic [DW-1:0] ebrd);
        vec_t v;
        v.a = a; v.b = b; v.cr = 1; v.ear = ear; v.ebr = ebr;
        v.cs = 1; v.earv = earv; v.eard = eard; v.ebrv = ebrv; v.ebrd = ebrd;
        return v;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.v    = 1'($urandom_range(0, 1));
        r.we   = 1'($urandom_range(0, 1));
        r.wm   = MW'($urandom_range(0, 15));
        r.addr = AW'($urandom_range(0, 15));
        r.wd   = $urandom;
        r.rr   = ($urandom_range(0, 3) != 0);
        return r;
    endfunction

    task automatic drive(input vec_t v);
        a_req_valid = v.a.v; a_req_we = v.a.we; a_req_wmask = v.a.wm;
        a_req_addr = v.a.addr; a_req_wdata = v.a.wd; a_rsp_ready = v.a.rr;
        b_req_valid = v.b.v; b_req_we = v.b.we; b_req_wmask = v.b.wm;
        b_req_addr = v.b.addr; b_req_wdata = v.b.wd; b_rsp_ready = v.b.rr;
    endtask

    task automatic model_step(input vec_t v, input int win);
        req_t r;
        bit   rr;
        m_we = 0;
        m_wmask = '0;
        if (win >= 0) begin
            r = (win == 0) ? v.a : v.b;
            m_ptr = 1 - win;
            m_addr = r.addr;
            if (r.we) begin
                m_we = 1; m_wmask = r.wm; m_din = r.wd;
                for (int l = 0; l < MW; l++)
                    if (r.wm[l]) m_mem[r.addr][8*l +: 8] = r.wd[8*l +: 8];
            end else begin
                m_out[win] = 1;
                m_pend[win] = 1;
                m_pdata[win] = m_mem[r.addr];
                m_pdue[win] = m_cyc + READ_LATENCY;
            end
        end
        for (int p = 0; p < 2; p++) begin
            rr = (p == 0) ? v.a.rr : v.b.rr;
            if (m_rv[p] && rr) begin
                m_rv[p] = 0;
                m_out[p] = 0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (m_pend[p] && m_pdue[p] == m_cyc + 1) begin
                m_rv[p] = 1;
                m_rd[p] = m_pdata[p];
                m_pend[p] = 0;
            end
        end
        m_cyc++;
    endtask

    task automatic run_cycle(input vec_t v);
        int win;
        bit ea, eb;
        @(negedge clk);
        chk("a_rsp_valid", 32'(a_rsp_valid), 32'(m_rv[0]));
        if (m_rv[0]) chk("a_rsp_rdata", a_rsp_rdata, m_rd[0]);
        chk("b_rsp_valid", 32'(b_rsp_valid), 32'(m_rv[1]));
        if (m_rv[1]) chk("b_rsp_rdata", b_rsp_rdata, m_rd[1]);
        chk("sram_we", 32'(sram_we), 32'(m_we));
        chk("sram_wmask", 32'(sram_wmask), 32'(m_wmask));
        chk("sram_addr", 32'(sram_addr), 32'(m_addr));
        if (m_we) chk("sram_din", sram_din, m_din);
        if (v.cs) begin
            chk("tab_a_rsp_valid", 32'(a_rsp_valid), 32'(v.earv));
            if (v.earv) chk("tab_a_rsp_rdata", a_rsp_rdata, v.eard);
            chk("tab_b_rsp_valid", 32'(b_rsp_valid), 32'(v.ebrv));
            if (v.ebrv) chk("tab_b_rsp_rdata", b_rsp_rdata, v.ebrd);
        end
        drive(v);
        #1;
        ea = v.a.v && (v.a.we || !m_out[0]);
        eb = v.b.v && (v.b.we || !m_out[1]);
        if (ea && eb)  win = m_ptr;
        else if (ea)   win = 0;
        else if (eb)   win = 1;
        else           win = -1;
        chk("a_req_ready", 32'(a_req_ready), 32'(win == 0));
        chk("b_req_ready", 32'(b_req_ready), 32'(win == 1));
        if (v.cr) begin
            chk("tab_a_req_ready", 32'(a_req_ready), 32'(v.ear));
            chk("tab_b_req_ready", 32'(b_req_ready), 32'(v.ebr));
        end
        last_ar = a_req_ready;
        last_br = b_req_ready;
        model_step(v, win);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_rsp_valid"}, 32'(a_rsp_valid), 0);
        chk({tag, "_b_rsp_valid"}, 32'(b_rsp_valid), 0);
        chk({tag, "_a_rsp_rdata"}, a_rsp_rdata, 0);
        chk({tag, "_b_rsp_rdata"}, b_rsp_rdata, 0);
        chk({tag, "_sram_we"}, 32'(sram_we), 0);
        chk({tag, "_sram_wmask"}, 32'(sram_wmask), 0);
        chk({tag, "_sram_addr"}, 32'(sram_addr), 0);
        chk({tag, "_sram_din"}, sram_din, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        drive('0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tab1[$];
        vec_t tab2[$];
        vec_t v;
        int   ngr;
        req_t ia, ib;

        for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
        m_cyc = 0;
        m_reset();
        ia = rq_idle(1);
        ib = rq_idle(1);

        // Basic write/read, byte mask, and contention on writes and reads.
        tab1.push_back(mkv(rq_wr(12'h005, 32'hDEADBEEF, 4'hF), ib, 1, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(rq_rd(12'h005, 1), ib, 1, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(ia, ib, 0, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(ia, ib, 0, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(ia, ib, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        tab1.push_back(mkv(rq_wr(12'h010, 32'h11223344, 4'hF), ib, 1, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(rq_wr(12'h010, 32'hAABBCCDD, 4'b0101), ib, 1, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(rq_rd(12'h010, 1), ib, 1, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(ia, ib, 0, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(ia, ib, 0, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(ia, ib, 0, 0, 1, 32'h11BB33DD, 0, 0));
        tab1.push_back(mkv(rq_wr(12'h001, 32'h1, 4'hF), rq_wr(12'h002, 32'h2, 4'hF), 0, 1, 0, 0, 0, 0));
        tab1.push_back(mkv(rq_wr(12'h001, 32'h1, 4'hF), ib, 1, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(rq_rd(12'h001, 1), rq_rd(12'h002, 1), 0, 1, 0, 0, 0, 0));
        tab1.push_back(mkv(rq_rd(12'h001, 1), rq_rd(12'h002, 1), 1, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(ia, ib, 0, 0, 0, 0, 0, 0));
        tab1.push_back(mkv(ia, ib, 0, 0, 0, 0, 1, 32'h2));
        tab1.push_back(mkv(ia, ib, 0, 0, 1, 32'h1, 0, 0));
        tab1.push_back(mkv(ia, ib, 0, 0, 0, 0, 0, 0));

        // A response back-pressured for five cycles: A reads stall, A writes and B proceed.
        tab2.push_back(mkv(rq_rd(12'h005, 0), ib, 1, 0, 0, 0, 0, 0));
        tab2.push_back(mkv(rq_rd(12'h005, 0), ib, 0, 0, 0, 0, 0, 0));
        tab2.push_back(mkv(rq_rd(12'h005, 0), ib, 0, 0, 0, 0, 0, 0));
        tab2.push_back(mkv(rq_rd(12'h005, 0), ib, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        tab2.push_back(mkv(rq_rd(12'h005, 0), rq_rd(12'h002, 1), 0, 1, 1, 32'hDEADBEEF, 0, 0));
        v = mkv(rq_wr(12'h020, 32'hCAFEF00D, 4'hF), ib, 1, 0, 1, 32'hDEADBEEF, 0, 0);
        v.a.rr = 0;
        tab2.push_back(v);
        tab2.push_back(mkv(rq_rd(12'h005, 0), ib, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        tab2.push_back(mkv(rq_rd(12'h005, 0), ib, 0, 0, 1, 32'hDEADBEEF, 1, 32'h2));
        tab2.push_back(mkv(rq_rd(12'h005, 1), ib, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        tab2.push_back(mkv(rq_rd(12'h020, 1), ib, 1, 0, 0, 0, 0, 0));
        tab2.push_back(mkv(ia, ib, 0, 0, 0, 0, 0, 0));
        tab2.push_back(mkv(ia, ib, 0, 0, 0, 0, 0, 0));
        tab2.push_back(mkv(ia, ib, 0, 0, 1, 32'hCAFEF00D, 0, 0));

        rst_n = 1'b0;
        drive('0);
        #3;
        check_reset_outputs("por");
        chk("por_a_req_ready", 32'(a_req_ready), 0);
        chk("por_b_req_ready", 32'(b_req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tab1[i]) run_cycle(tab1[i]);

        // Both ports reading every cycle: grants must alternate starting with A.
        do_reset("rst_alt");
        ngr = 0;
        for (int c = 0; c < 16; c++) begin
            v = '0;
            v.a = rq_rd(12'h001, 1);
            v.b = rq_rd(12'h002, 1);
            run_cycle(v);
            if (last_ar || last_br) begin
                chk("alt_order", 32'(last_br), 32'(ngr % 2));
                ngr++;
            end
        end
        chk("alt_count", 32'(ngr), 8);

        do_reset("rst_bp");
        foreach (tab2[i]) run_cycle(tab2[i]);

        // Reset pulsed while a B read is in flight.
        do_reset("rst_mid0");
        run_cycle(mkv(ia, rq_rd(12'h002, 1), 0, 1, 0, 0, 0, 0));
        @(negedge clk);
        drive('0);
        chk("pre_rst_sram_addr", 32'(sram_addr), 32'h002);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            run_cycle(mkv(ia, ib, 0, 0, 0, 0, 0, 0));
            chk("rst_drop_b_rsp_valid", 32'(b_rsp_valid), 0);
        end

        for (int c = 0; c < 400; c++) begin
            v = '0;
            v.a = rnd_req();
            v.b = rnd_req();
            run_cycle(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
